// File: rtl/sine_wave_pkg.sv
// Shared definitions for the sine-wave generator CSR map and its sweep master.
package sine_wave_pkg;
  localparam int unsigned SIN_W = 10;
  localparam int unsigned FCW_W = 8;

  localparam logic [1:0] ADDR_FCW = 2'd0;
  localparam logic [1:0] ADDR_RUN = 2'd1;
  localparam logic [1:0] ADDR_SIN = 2'd2;

  typedef enum logic [2:0] {
    IDLE, WR_FCW, WR_RUN, RD_REQ, RD_WAIT, GAP, WR_STOP, FIN
  } sweep_state_t;

  typedef enum logic [1:0] {
    CMD_NONE, CMD_WRITE, CMD_READ
  } avm_cmd_t;
endpackage

// File: rtl/avm_cmd_issuer.sv
// Avalon-MM command driver: presents the sequencer's command, reports acceptance,
// and flags when fixed-latency read data is valid.
module avm_cmd_issuer
  import sine_wave_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  avm_cmd_t    cmd,
  input  logic [1:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        accept,
  output logic        rdata_valid,
  output logic        avm_chipselect,
  output logic        avm_write,
  output logic        avm_read,
  output logic [1:0]  avm_address,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);
  localparam int unsigned LAT_W = $clog2(READ_LATENCY + 1);

  logic [LAT_W-1:0] lat_q, lat_d;

  // The sequencer holds cmd steady until accept, so the bus stays stable under waitrequest.
  always_comb begin
    avm_chipselect = (cmd != CMD_NONE);
    avm_write      = (cmd == CMD_WRITE);
    avm_read       = (cmd == CMD_READ);
    avm_address    = avm_chipselect ? cmd_addr : '0;
    avm_writedata  = avm_write ? cmd_wdata : '0;
    accept         = avm_chipselect && !avm_waitrequest;
    rdata_valid    = (lat_q == LAT_W'(1));
    lat_d          = lat_q;
    if (avm_read && accept) begin
      lat_d = LAT_W'(READ_LATENCY);
    end else if (lat_q != '0) begin
      lat_d = lat_q - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lat_q <= '0;
    else     lat_q <= lat_d;
  end
endmodule

// File: rtl/sine_wave_sweep_master.sv
// Sweep sequencer: programs FCW, sets run, polls N samples at a fixed gap,
// then clears run. Bus handshaking lives in avm_cmd_issuer.
module sine_wave_sweep_master
  import sine_wave_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned SAMPLE_GAP   = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             abort,
  input  logic [FCW_W-1:0] fcw_in,
  input  logic [CNT_W-1:0] num_samples,
  output logic             busy,
  output logic             done,
  output logic             sample_valid,
  output logic [SIN_W-1:0] sample_data,
  output logic             avm_chipselect,
  output logic             avm_write,
  output logic             avm_read,
  output logic [1:0]       avm_address,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest
);
  localparam int unsigned GAP_W = $clog2(SAMPLE_GAP + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((SAMPLE_GAP > 0) ? SAMPLE_GAP - 1 : 0);

  sweep_state_t     state_q, state_d;
  logic [FCW_W-1:0] fcw_q, fcw_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             abort_q, abort_d;
  logic [SIN_W-1:0] sample_data_q, sample_data_d;
  logic             sample_valid_q, sample_valid_d;

  avm_cmd_t    cmd;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        accept, rdata_valid, stop_req;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^avm_readdata[31:SIN_W];

  avm_cmd_issuer #(.READ_LATENCY(READ_LATENCY)) u_issuer (
    .clk             (Clk),
    .rst             (Reset),
    .cmd             (cmd),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .accept          (accept),
    .rdata_valid     (rdata_valid),
    .avm_chipselect  (avm_chipselect),
    .avm_write       (avm_write),
    .avm_read        (avm_read),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest)
  );

  always_comb begin
    state_d        = state_q;
    fcw_d          = fcw_q;
    num_d          = num_q;
    cnt_d          = cnt_q;
    gap_d          = gap_q;
    abort_d        = abort_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = 1'b0;
    cmd            = CMD_NONE;
    cmd_addr       = ADDR_FCW;
    cmd_wdata      = '0;
    done           = 1'b0;
    stop_req       = abort_q || abort;
    if (state_q != IDLE && abort) abort_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          fcw_d   = fcw_in;
          num_d   = num_samples;
          cnt_d   = '0;
          state_d = WR_FCW;
        end
      end
      WR_FCW: begin
        cmd       = CMD_WRITE;
        cmd_addr  = ADDR_FCW;
        cmd_wdata = 32'(fcw_q);
        if (accept) state_d = WR_RUN;
      end
      WR_RUN: begin
        cmd       = CMD_WRITE;
        cmd_addr  = ADDR_RUN;
        cmd_wdata = 32'h1;
        if (accept) state_d = (num_q == '0 || stop_req) ? WR_STOP : RD_REQ;
      end
      RD_REQ: begin
        cmd      = CMD_READ;
        cmd_addr = ADDR_SIN;
        if (accept) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rdata_valid) begin
          sample_data_d  = avm_readdata[SIN_W-1:0];
          sample_valid_d = 1'b1;
          cnt_d          = cnt_q + CNT_W'(1);
          // Compare against num-1 so a full-scale count finishes without relying on wrap.
          if (cnt_q == num_q - CNT_W'(1) || stop_req) begin
            state_d = WR_STOP;
          end else if (SAMPLE_GAP == 0) begin
            state_d = RD_REQ;
          end else begin
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end
      GAP: begin
        if (stop_req)              state_d = WR_STOP;
        else if (gap_q == GAP_LAST) state_d = RD_REQ;
        else                       gap_d   = gap_q + GAP_W'(1);
      end
      WR_STOP: begin
        cmd       = CMD_WRITE;
        cmd_addr  = ADDR_RUN;
        cmd_wdata = 32'h0;
        if (accept) state_d = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      fcw_q          <= '0;
      num_q          <= '0;
      cnt_q          <= '0;
      gap_q          <= '0;
      abort_q        <= 1'b0;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      fcw_q          <= fcw_d;
      num_q          <= num_d;
      cnt_q          <= cnt_d;
      gap_q          <= gap_d;
      abort_q        <= abort_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign busy         = (state_q != IDLE) && (state_q != FIN);
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
endmodule

// File: tb/tb_sine_wave_sweep_master.sv
// Directed bench: a small Avalon slave model logs accepted commands and
// returns registered read data; a linear sequence checks each sweep.
module tb_sine_wave_sweep_master;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  fcw_in = '0;
  logic [15:0] num_samples = '0;
  logic        busy, done, sample_valid;
  logic [9:0]  sample_data;
  logic        avm_chipselect, avm_write, avm_read;
  logic [1:0]  avm_address;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'hDEAD_B0AB;
  logic        avm_waitrequest = 1'b0;

  localparam logic [31:0] JUNK = 32'hDEAD_B0AB;

  sine_wave_sweep_master #(.READ_LATENCY(1), .SAMPLE_GAP(4), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .abort(abort),
    .fcw_in(fcw_in), .num_samples(num_samples),
    .busy(busy), .done(done), .sample_valid(sample_valid), .sample_data(sample_data),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
    .avm_address(avm_address), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Slave-model state and logs; written only by the slave process.
  logic [35:0] lg_cmd [0:63];
  int          lg_cyc [0:63];
  int          nlog = 0;
  logic [9:0]  sv_data [0:63];
  int          nsv = 0;
  int          ndone = 0;
  int          done_cyc = 0;
  logic        busy_at_done = 1'b1;
  int          rd_total = 0;
  int          rd_idx = 0;
  int          cyc = 0;
  int          stab_viol = 0;
  int          stall_cycles = 0;
  int          stall_cnt = 0;
  logic        stall_en = 1'b0;
  logic        prev_stalled = 1'b0;
  logic        rd_pend = 1'b0;
  logic [36:0] held = '0;

  function automatic logic [31:0] rd_val(int j);
    case (j)
      0:       return 32'hA5A5_A7FF;
      1:       return 32'h1234_5600;
      2:       return 32'hFFFF_FC01;
      default: return {22'h2A_AAAA, 10'(j * 37 + 5)};
    endcase
  endfunction

  function automatic logic [9:0] sval(int j);
    logic [31:0] v;
    v = rd_val(j);
    return v[9:0];
  endfunction

  // {kind, addr, data}: kind 1 = write, 2 = read
  function automatic logic [35:0] wr_cmd(logic [1:0] a, logic [31:0] d);
    return {2'd1, a, d};
  endfunction
  localparam logic [35:0] RD_SIN = {2'd2, 2'd2, 32'h0};

  always begin
    @(negedge Clk);
    cyc++;
    if (prev_stalled && {avm_chipselect, avm_read, avm_write, avm_address, avm_writedata} !== held)
      stab_viol++;
    if (avm_read && avm_write) stab_viol++;
    if (avm_chipselect && stall_en && stall_cnt < 5) begin
      avm_waitrequest = 1'b1;
      stall_cnt++;
      stall_cycles++;
    end else begin
      avm_waitrequest = 1'b0;
    end
    prev_stalled = avm_chipselect && avm_waitrequest;
    held = {avm_chipselect, avm_read, avm_write, avm_address, avm_writedata};
    rd_pend = 1'b0;
    if (avm_chipselect && !avm_waitrequest) begin
      stall_cnt = 0;
      if (nlog < 64) begin
        lg_cmd[nlog] = {avm_read, avm_write, avm_address, avm_writedata};
        lg_cyc[nlog] = cyc;
      end
      nlog++;
      if (avm_read) begin
        rd_pend = 1'b1;
        rd_idx  = rd_total;
        rd_total++;
      end
    end
    if (sample_valid) begin
      if (nsv < 64) sv_data[nsv] = sample_data;
      nsv++;
    end
    if (done) begin
      ndone++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    @(posedge Clk);
    #1;
    avm_readdata = rd_pend ? rd_val(rd_idx) : JUNK;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic run_sweep(input logic [7:0] f, input logic [15:0] n);
    fcw_in = f;
    num_samples = n;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge Clk);
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    tick(1);
  endtask

  task automatic wait_read(input int nth);
    int nr;
    nr = 0;
    for (int k = 0; k < 200 && nr < nth; k++) begin
      @(negedge Clk);
      if (avm_read) nr++;
    end
    chk("read_seen", 64'(nr), 64'(nth));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, sample_valid, sample_data, avm_chipselect, avm_write,
                avm_read, avm_address, avm_writedata});
  endfunction

  initial begin
    int b, sb, rb, d0, sc0;

    tick(2);
    chk("reset_outputs", all_outs(), 64'd0);
    Reset = 1'b0;
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    chk("idle_abort_busy", 64'(busy), 64'd0);

    // Basic sweep (an idle abort must not leak into it)
    b = nlog; sb = nsv; d0 = ndone;
    run_sweep(8'h10, 16'd3);
    chk("basic_busy", 64'(busy), 64'd1);
    wait_done("basic", 200);
    chk("basic_ncmd", 64'(nlog - b), 64'd6);
    chk("basic_fcw",  64'(lg_cmd[b+0]), 64'(wr_cmd(2'd0, 32'h10)));
    chk("basic_run",  64'(lg_cmd[b+1]), 64'(wr_cmd(2'd1, 32'h1)));
    chk("basic_rd0",  64'(lg_cmd[b+2]), 64'(RD_SIN));
    chk("basic_rd1",  64'(lg_cmd[b+3]), 64'(RD_SIN));
    chk("basic_rd2",  64'(lg_cmd[b+4]), 64'(RD_SIN));
    chk("basic_stop", 64'(lg_cmd[b+5]), 64'(wr_cmd(2'd1, 32'h0)));
    chk("basic_gap01", 64'(lg_cyc[b+3] - lg_cyc[b+2]), 64'd6);
    chk("basic_gap12", 64'(lg_cyc[b+4] - lg_cyc[b+3]), 64'd6);
    chk("basic_nsamp", 64'(nsv - sb), 64'd3);
    chk("basic_s0", 64'(sv_data[sb+0]), 64'h3FF);
    chk("basic_s1", 64'(sv_data[sb+1]), 64'h200);
    chk("basic_s2", 64'(sv_data[sb+2]), 64'h001);
    chk("basic_ndone", 64'(ndone - d0), 64'd1);
    chk("basic_done_lat", 64'(done_cyc - lg_cyc[b+5]), 64'd1);
    chk("basic_busy_at_done", 64'(busy_at_done), 64'd0);
    chk("basic_busy_after", 64'(busy), 64'd0);

    // Waitrequest stall on every command
    b = nlog; sb = nsv; rb = rd_total; sc0 = stall_cycles;
    stall_en = 1'b1;
    run_sweep(8'h10, 16'd3);
    wait_done("stall", 400);
    stall_en = 1'b0;
    chk("stall_ncmd", 64'(nlog - b), 64'd6);
    chk("stall_fcw",  64'(lg_cmd[b+0]), 64'(wr_cmd(2'd0, 32'h10)));
    chk("stall_run",  64'(lg_cmd[b+1]), 64'(wr_cmd(2'd1, 32'h1)));
    chk("stall_rd2",  64'(lg_cmd[b+4]), 64'(RD_SIN));
    chk("stall_stop", 64'(lg_cmd[b+5]), 64'(wr_cmd(2'd1, 32'h0)));
    chk("stall_cycles", 64'(stall_cycles - sc0), 64'd30);
    chk("stall_stability", 64'(stab_viol), 64'd0);
    chk("stall_nsamp", 64'(nsv - sb), 64'd3);
    chk("stall_s0", 64'(sv_data[sb+0]), 64'(sval(rb)));
    chk("stall_s2", 64'(sv_data[sb+2]), 64'(sval(rb + 2)));

    // Zero samples
    b = nlog; sb = nsv; rb = rd_total; d0 = ndone;
    run_sweep(8'h7E, 16'd0);
    wait_done("zero", 100);
    chk("zero_ncmd", 64'(nlog - b), 64'd3);
    chk("zero_fcw",  64'(lg_cmd[b+0]), 64'(wr_cmd(2'd0, 32'h7E)));
    chk("zero_run",  64'(lg_cmd[b+1]), 64'(wr_cmd(2'd1, 32'h1)));
    chk("zero_stop", 64'(lg_cmd[b+2]), 64'(wr_cmd(2'd1, 32'h0)));
    chk("zero_nreads", 64'(rd_total - rb), 64'd0);
    chk("zero_nsamp", 64'(nsv - sb), 64'd0);
    chk("zero_ndone", 64'(ndone - d0), 64'd1);

    // Abort in the cycle after the 2nd read is accepted
    b = nlog; sb = nsv; rb = rd_total; d0 = ndone;
    run_sweep(8'h05, 16'd10);
    wait_read(2);
    @(negedge Clk);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    wait_done("abort", 100);
    chk("abort_ncmd", 64'(nlog - b), 64'd5);
    chk("abort_rd1",  64'(lg_cmd[b+3]), 64'(RD_SIN));
    chk("abort_stop", 64'(lg_cmd[b+4]), 64'(wr_cmd(2'd1, 32'h0)));
    chk("abort_nsamp", 64'(nsv - sb), 64'd2);
    chk("abort_s1", 64'(sv_data[sb+1]), 64'(sval(rb + 1)));
    chk("abort_ndone", 64'(ndone - d0), 64'd1);

    // Reset during the gap after sample 1, then a clean sweep
    run_sweep(8'h40, 16'd5);
    begin
      logic got_sv;
      got_sv = 1'b0;
      for (int k = 0; k < 100 && !got_sv; k++) begin
        @(negedge Clk);
        if (sample_valid) got_sv = 1'b1;
      end
      chk("rst_sample1_seen", 64'(got_sv), 64'd1);
    end
    #1 Reset = 1'b1;
    #1 chk("rst_async_outputs", all_outs(), 64'd0);
    tick(2);
    Reset = 1'b0;
    tick(1);
    b = nlog; sb = nsv; rb = rd_total; d0 = ndone;
    run_sweep(8'h22, 16'd1);
    wait_done("rst", 100);
    chk("rst_ncmd", 64'(nlog - b), 64'd4);
    chk("rst_fcw",  64'(lg_cmd[b+0]), 64'(wr_cmd(2'd0, 32'h22)));
    chk("rst_run",  64'(lg_cmd[b+1]), 64'(wr_cmd(2'd1, 32'h1)));
    chk("rst_rd",   64'(lg_cmd[b+2]), 64'(RD_SIN));
    chk("rst_stop", 64'(lg_cmd[b+3]), 64'(wr_cmd(2'd1, 32'h0)));
    chk("rst_s0", 64'(sv_data[sb]), 64'(sval(rb)));
    chk("rst_ndone", 64'(ndone - d0), 64'd1);

    // Start while busy is ignored
    b = nlog; sb = nsv; d0 = ndone;
    run_sweep(8'h55, 16'd2);
    wait_read(1);
    @(negedge Clk);
    fcw_in = 8'h99;
    num_samples = 16'd7;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    wait_done("busy_start", 100);
    tick(20);
    chk("busy_start_ncmd", 64'(nlog - b), 64'd5);
    chk("busy_start_fcw",  64'(lg_cmd[b+0]), 64'(wr_cmd(2'd0, 32'h55)));
    chk("busy_start_stop", 64'(lg_cmd[b+4]), 64'(wr_cmd(2'd1, 32'h0)));
    chk("busy_start_nsamp", 64'(nsv - sb), 64'd2);
    chk("busy_start_ndone", 64'(ndone - d0), 64'd1);
    chk("busy_start_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sine_wave_sweep_master.md
Name: sine_wave_sweep_master

Overview:
- Avalon-MM master that drives the sine-wave generator's CSR slave from the other end of the same bus.
- Programs the frequency control word (address 0) and sets run (address 1).
- Polls the sine sample (address 2) a programmed number of times at a fixed interval, streaming each sample out.
- Clears run when finished. Sits between a local controller (or test sequencer) and the generator's CSR port.

Parameters:
- READ_LATENCY, 1, cycles from the accepted read command to valid avm_readdata (fixed latency; the slave registers read data).
- SAMPLE_GAP, 4, idle cycles between the end of one sample read and the next read command (0 allowed).
- CNT_W, 16, width of the sample counter and num_samples.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep when idle.
- abort  input  1  one-cycle pulse; ends the sweep early (run is still cleared).
- fcw_in  input  8  frequency control word, captured on accepted start.
- num_samples  input  CNT_W  sample reads to perform, captured on accepted start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse when the sweep completes or aborts.
- sample_valid  output  1  one-cycle pulse per captured sample.
- sample_data  output  10  avm_readdata[9:0] of the latest sample read.
- avm_chipselect  output  1  Avalon chip select.
- avm_write  output  1  write strobe.
- avm_read  output  1  read strobe.
- avm_address  output  2  word address.
- avm_writedata  output  32  write data.
- avm_readdata  input  32  read data.
- avm_waitrequest  input  1  slave stall; a command is accepted on a cycle where it is asserted and waitrequest=0.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-transaction drops the bus command immediately. No run=0 write is issued, so the slave's own reset is relied on.
- States: IDLE, WR_FCW, WR_RUN, RD_REQ, RD_WAIT, GAP, WR_STOP, FIN.
- IDLE: start=1 latches fcw_in and num_samples, sets busy, goes to WR_FCW. A start while busy is ignored.
- WR_FCW: chipselect=1, write=1, address=0, writedata={24'h0,fcw}. Held stable until accepted, then WR_RUN.
- WR_RUN: chipselect=1, write=1, address=1, writedata=32'h1. On accept:
  - num_samples=0 goes to WR_STOP.
  - otherwise goes to RD_REQ.
- RD_REQ: chipselect=1, read=1, address=2. On accept, load the latency counter with READ_LATENCY and go to RD_WAIT.
- RD_WAIT: no bus command. When the latency count expires:
  - capture avm_readdata[9:0] into sample_data and pulse sample_valid in the same cycle;
  - increment the sample counter;
  - if count==num_samples or abort is pending, go to WR_STOP;
  - else go to GAP, or straight to RD_REQ when SAMPLE_GAP=0.
- GAP: waits SAMPLE_GAP cycles, then RD_REQ. An abort pending here goes to WR_STOP.
- WR_STOP: chipselect=1, write=1, address=1, writedata=32'h0. On accept, go to FIN.
- FIN: pulse done, clear busy, return to IDLE. done is asserted one cycle after the stop write is accepted.
- Command stability: while waitrequest=1, chipselect, read, write, address and writedata are held unchanged. read and write are never asserted together.
- Abort handling:
  - abort while busy is latched as pending.
  - An in-flight command always completes first; aborting mid-read still delivers that sample.
  - Abort during WR_FCW or WR_RUN takes effect after WR_RUN, which goes to WR_STOP.
  - abort while IDLE is ignored.
  - abort and start in the same cycle while IDLE: start wins.
- Counter at max: num_samples = 2^CNT_W-1 completes normally with no wrap; compare before increment overflow.
- sample_data holds its value between samples.

Decomposition:
- Shared package sine_wave_pkg holds:
  - CSR address constants ADDR_FCW=0, ADDR_RUN=1, ADDR_SIN=2;
  - SIN_W=10, FCW_W=8;
  - the state enum.
- The CSR slave and this master both import it.
- One sub-module is natural: avm_cmd_issuer. It holds the command until waitrequest is low, reports accept, and tracks read latency, so the FSM only sequences.

Test Plan:
- Basic sweep: start with fcw_in=8'h10, num_samples=3, SAMPLE_GAP=4, waitrequest=0.
  - Bus sequence: write@0=0x10, write@1=1, three reads@2 spaced 4 idle cycles apart, write@1=0.
  - Three sample_valid pulses carry the readdata[9:0] values 0x3FF, 0x200, 0x001.
  - One done pulse; busy falls with done.
- Waitrequest stall: hold waitrequest=1 for 5 cycles on each command.
  - Command signals are held constant throughout the stall.
  - Each command is accepted exactly once; sample count is still 3.
- Zero samples: num_samples=0 → write@0, write@1=1, write@1=0, done; no read issued; sample_valid never pulses.
- Abort during a read: abort in the cycle after the 2nd read is accepted, with num_samples=10.
  - The 2nd sample is still delivered.
  - Then write@1=0 and done; exactly 2 samples total.
- Reset mid-sweep: assert Reset during the GAP after sample 1.
  - All outputs go to 0 asynchronously.
  - After Reset deasserts, start with fcw_in=8'h22, num_samples=1 runs a full clean sequence.
- Start while busy: a second start pulse during RD_WAIT with a different fcw_in is ignored; the sweep uses the original fcw and count.
